// File: rtl/stream_fifo_level.sv
// stream_fifo_level: valid/ready FIFO of any depth with an exact occupancy
// count, runtime almost-full/almost-empty flags, a high-water mark and a
// synchronous flush. Storage is a distributed (combinational-read) memory,
// optionally followed by a one-entry output register.
module stream_fifo_level #(
  parameter logic        CLOCK_INFO        = 1'b0,
  parameter string       TECHNOLOGY        = "STD_TECHNOLOGY_FPGA_XILINX",
  parameter int unsigned DEPTH             = 16,
  parameter type         T                 = logic,
  parameter bit          OUTPUT_REGISTERED = 1'b1,
  localparam int unsigned CW               = $clog2(DEPTH + 1),
  localparam int unsigned PW               = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  // write stream
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  T              i_in_payload,
  // read stream
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output T              o_out_payload,
  // control and telemetry
  input  logic          i_flush,
  input  logic [CW-1:0] i_almost_full_threshold,
  input  logic [CW-1:0] i_almost_empty_threshold,
  output logic [CW-1:0] o_count,
  output logic          o_almost_full,
  output logic          o_almost_empty,
  output logic [CW-1:0] o_high_water
);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ready_en;
  logic          r_af;
  logic          r_ae;
  logic [CW-1:0] r_hw;

  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_pop;
  logic [PW-1:0] w_wptr_next;
  logic [PW-1:0] w_rptr_next;
  logic [CW-1:0] w_count_next;
  logic [CW-1:0] w_hw_next;

  // Write side accepts only from registered state and flush
  assign o_in_ready = r_ready_en & ~i_flush & (r_count < CW'(DEPTH));
  assign w_in_fire  = i_in_valid & o_in_ready;
  assign w_out_fire = o_out_valid & i_out_ready;

  if (OUTPUT_REGISTERED) begin : g_oreg
    logic r_ov;
    T     r_oq;
    logic w_mem_nonempty;

    // count includes the output register, so memory occupancy is count - r_ov
    assign w_mem_nonempty = (r_count != CW'(r_ov));
    assign w_pop          = w_mem_nonempty & (~r_ov | w_out_fire);
    assign o_out_valid    = r_ov & ~i_flush;
    assign o_out_payload  = r_oq;

    // Output register occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_ov <= 1'b0;
      end else if (i_flush) begin
        r_ov <= 1'b0;
      end else if (w_pop) begin
        r_ov <= 1'b1;
      end else if (w_out_fire) begin
        r_ov <= 1'b0;
      end
    end

    // Output register data, loaded from the head of memory
    always_ff @(posedge i_clk) begin
      if (w_pop) begin
        r_oq <= r_mem[r_rptr];
      end
    end
  end else begin : g_ocomb
    assign w_pop         = w_out_fire;
    assign o_out_valid   = (r_count != '0) & ~i_flush;
    assign o_out_payload = r_mem[r_rptr];
  end

  // Pointer wrap for arbitrary depth, next count and high-water mark
  always_comb begin
    w_wptr_next  = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
    w_rptr_next  = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
    w_count_next = r_count + CW'(w_in_fire) - CW'(w_out_fire);
    if (i_flush) begin
      w_count_next = '0;
    end
    w_hw_next = (w_count_next > r_hw) ? w_count_next : r_hw;
    if (i_flush) begin
      w_hw_next = '0;
    end
  end

  // Storage write port
  always_ff @(posedge i_clk) begin
    if (w_in_fire) begin
      r_mem[r_wptr] <= i_in_payload;
    end
  end

  // Control state: ready enable, pointers, count and level flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready_en <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_af       <= 1'b0;
      r_ae       <= 1'b1;
      r_hw       <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_count    <= w_count_next;
      if (i_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_in_fire) begin
          r_wptr <= w_wptr_next;
        end
        if (w_pop) begin
          r_rptr <= w_rptr_next;
        end
      end
      r_af <= (w_count_next >= i_almost_full_threshold);
      r_ae <= (w_count_next <= i_almost_empty_threshold);
      r_hw <= w_hw_next;
    end
  end

  assign o_count        = r_count;
  assign o_almost_full  = r_af;
  assign o_almost_empty = r_ae;
  assign o_high_water   = r_hw;

endmodule

// File: tb/tb_stream_fifo_level.sv
// Directed bench for stream_fifo_level: DEPTH=5 with combinational output
// (dut a) and with registered output (dut b).
module tb_stream_fifo_level;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] af_thr = 3'd4;
  logic [2:0] ae_thr = 3'd1;

  logic       a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_flush = 1'b0;
  logic [7:0] a_in_data = '0, a_out_data;
  logic [2:0] a_count, a_hw;
  logic       a_af, a_ae;

  logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic [7:0] b_in_data = '0, b_out_data;
  logic [2:0] b_count, b_hw;
  logic       b_af, b_ae;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  stream_fifo_level #(.DEPTH(5), .T(logic [7:0]), .OUTPUT_REGISTERED(1'b0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_payload(a_in_data),
    .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_out_payload(a_out_data),
    .i_flush(a_flush), .i_almost_full_threshold(af_thr), .i_almost_empty_threshold(ae_thr),
    .o_count(a_count), .o_almost_full(a_af), .o_almost_empty(a_ae), .o_high_water(a_hw)
  );

  stream_fifo_level #(.DEPTH(5), .T(logic [7:0]), .OUTPUT_REGISTERED(1'b1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_payload(b_in_data),
    .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_payload(b_out_data),
    .i_flush(1'b0), .i_almost_full_threshold(af_thr), .i_almost_empty_threshold(ae_thr),
    .o_count(b_count), .o_almost_full(b_af), .o_almost_empty(b_ae), .o_high_water(b_hw)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    total++; if (a_in_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", a_in_ready); else passed++;
    total++; if (a_out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", a_out_valid); else passed++;
    total++; if (a_count !== 3'd0) $display("FAIL rst_count: got %0d want 0", a_count); else passed++;
    total++; if ({a_af, a_ae} !== 2'b01) $display("FAIL rst_flags: got af=%b ae=%b want af=0 ae=1", a_af, a_ae); else passed++;
    total++; if (a_hw !== 3'd0) $display("FAIL rst_hw: got %0d want 0", a_hw); else passed++;
    rst_n = 1'b1;
    #1;
    total++; if (a_in_ready !== 1'b0) $display("FAIL rst_release_ready: got %b want 0", a_in_ready); else passed++;
    step();
    total++; if (a_in_ready !== 1'b1) $display("FAIL rst_first_edge_ready: got %b want 1", a_in_ready); else passed++;
  endtask

  task automatic test_fill_drain();
    a_out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(i);
      #1;
      total++; if (a_in_ready !== (i <= 5)) $display("FAIL fill_ready[%0d]: got %b want %b", i, a_in_ready, (i <= 5)); else passed++;
      step();
    end
    a_in_valid = 1'b0;
    total++; if (a_count !== 3'd5) $display("FAIL fill_count: got %0d want 5", a_count); else passed++;
    total++; if (a_hw !== 3'd5) $display("FAIL fill_hw: got %0d want 5", a_hw); else passed++;
    total++; if ({a_af, a_ae} !== 2'b10) $display("FAIL fill_flags: got af=%b ae=%b want af=1 ae=0", a_af, a_ae); else passed++;
    a_out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      #1;
      total++; if (!(a_out_valid === 1'b1 && a_out_data === 8'(i)))
        $display("FAIL drain[%0d]: got v=%b d=%h want v=1 d=%h", i, a_out_valid, a_out_data, 8'(i)); else passed++;
      step();
    end
    a_out_ready = 1'b0;
    total++; if (a_count !== 3'd0) $display("FAIL drain_count: got %0d want 0", a_count); else passed++;
    total++; if (a_ae !== 1'b1) $display("FAIL drain_ae: got %b want 1", a_ae); else passed++;
    total++; if (a_out_valid !== 1'b0) $display("FAIL drain_valid: got %b want 0", a_out_valid); else passed++;
  endtask

  task automatic test_stream();
    a_out_ready = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      a_in_valid = (k < 13);
      a_in_data  = 8'(8'h10 + k);
      #1;
      if (k == 0) begin
        total++; if (a_out_valid !== 1'b0) $display("FAIL stream_no_passthru: got %b want 0", a_out_valid); else passed++;
      end else begin
        total++; if (!(a_out_valid === 1'b1 && a_out_data === 8'(8'h10 + k - 1) && a_count === 3'd1))
          $display("FAIL stream[%0d]: got v=%b d=%h c=%0d want v=1 d=%h c=1", k, a_out_valid, a_out_data, a_count, 8'(8'h10 + k - 1));
        else passed++;
      end
      step();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    total++; if (a_count !== 3'd0) $display("FAIL stream_end_count: got %0d want 0", a_count); else passed++;
  endtask

  task automatic test_registered_stream();
    b_out_ready = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      logic [2:0] exp_c;
      logic       exp_v;
      b_in_valid = (k < 13);
      b_in_data  = 8'(8'h10 + k);
      exp_c = (k == 0 || k == 15) ? 3'd0 : (k == 1 || k == 14) ? 3'd1 : 3'd2;
      exp_v = (k >= 2 && k <= 14);
      #1;
      total++; if (b_out_valid !== exp_v || b_count !== exp_c || (exp_v && b_out_data !== 8'(8'h10 + k - 2)))
        $display("FAIL reg_stream[%0d]: got v=%b d=%h c=%0d want v=%b d=%h c=%0d", k, b_out_valid, b_out_data, b_count, exp_v, 8'(8'h10 + k - 2), exp_c);
      else passed++;
      step();
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b0;
  endtask

  task automatic test_full_simul();
    // inputs: in_v, in_d, out_r ; expected: ready, out_v, out_d, count
    logic [7:0] in_d  [9] = '{8'h26, 8'h26, 8'h27, 8'h00, 8'h00, 8'h28, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_d [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h00};
    logic [2:0] exp_c [9] = '{3'd5, 3'd4, 3'd4, 3'd4, 3'd3, 3'd2, 3'd2, 3'd1, 3'd0};
    logic [8:0] in_v  = 9'b000100111;  // bit k = cycle k
    logic [8:0] exp_r = 9'b111111110;
    logic [8:0] exp_v = 9'b011111111;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(8'h21 + i);
      step();
    end
    a_in_data = 8'h26;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (a_in_ready !== 1'b0 || a_count !== 3'd5)
        $display("FAIL full_hold[%0d]: got r=%b c=%0d want r=0 c=5", i, a_in_ready, a_count); else passed++;
      step();
    end
    for (int k = 0; k < 9; k++) begin
      a_in_valid  = in_v[k];
      a_in_data   = in_d[k];
      a_out_ready = (k < 8);
      #1;
      total++; if (a_in_ready !== exp_r[k] || a_out_valid !== exp_v[k] || a_count !== exp_c[k] ||
                   (exp_v[k] && a_out_data !== exp_d[k]))
        $display("FAIL full_simul[%0d]: got r=%b v=%b d=%h c=%0d want r=%b v=%b d=%h c=%0d", k,
                 a_in_ready, a_out_valid, a_out_data, a_count, exp_r[k], exp_v[k], exp_d[k], exp_c[k]);
      else passed++;
      step();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
  endtask

  task automatic test_thresholds();
    logic [5:0] exp_ae = 6'b000011;  // bit n = expected flag at count n
    logic [5:0] exp_af = 6'b110000;
    for (int n = 0; n <= 5; n++) begin
      a_in_valid = (n < 5);
      a_in_data  = 8'(n);
      #1;
      total++; if (a_count !== 3'(n) || a_ae !== exp_ae[n] || a_af !== exp_af[n])
        $display("FAIL thr_fill[%0d]: got c=%0d ae=%b af=%b want c=%0d ae=%b af=%b", n, a_count, a_ae, a_af, n, exp_ae[n], exp_af[n]);
      else passed++;
      step();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    step();
    step();
    a_out_ready = 1'b0;
    af_thr = 3'd2;
    #1;
    total++; if (a_count !== 3'd3 || a_af !== 1'b0) $display("FAIL thr_change_before: got c=%0d af=%b want c=3 af=0", a_count, a_af); else passed++;
    step();
    total++; if (a_af !== 1'b1) $display("FAIL thr_change_after: got af=%b want 1", a_af); else passed++;
    af_thr = 3'd4;
    step();
    total++; if (a_af !== 1'b0) $display("FAIL thr_restore: got af=%b want 0", a_af); else passed++;
    a_out_ready = 1'b1;
    repeat (3) step();
    a_out_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(8'h31 + i);
      step();
    end
    a_in_data   = 8'h99;
    a_out_ready = 1'b1;
    a_flush     = 1'b1;
    #1;
    total++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0)
      $display("FAIL flush_gate: got r=%b v=%b want r=0 v=0", a_in_ready, a_out_valid); else passed++;
    step();
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    total++; if (a_count !== 3'd0 || a_hw !== 3'd0 || a_out_valid !== 1'b0 || a_ae !== 1'b1)
      $display("FAIL flush_after: got c=%0d hw=%0d v=%b ae=%b want c=0 hw=0 v=0 ae=1", a_count, a_hw, a_out_valid, a_ae);
    else passed++;
    a_in_valid = 1'b1;
    a_in_data  = 8'h0A;
    step();
    a_in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h0A || a_count !== 3'd1 || a_hw !== 3'd1)
      $display("FAIL flush_new_word: got v=%b d=%h c=%0d hw=%0d want v=1 d=0a c=1 hw=1", a_out_valid, a_out_data, a_count, a_hw);
    else passed++;
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    total++; if (a_count !== 3'd0) $display("FAIL flush_read_count: got %0d want 0", a_count); else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(8'h41 + i);
      step();
    end
    total++; if (a_count !== 3'd4 || a_af !== 1'b1) $display("FAIL prereset: got c=%0d af=%b want c=4 af=1", a_count, a_af); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (a_count !== 3'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_af !== 1'b0 || a_ae !== 1'b1 || a_hw !== 3'd0)
      $display("FAIL async_reset: got c=%0d v=%b r=%b af=%b ae=%b hw=%0d want c=0 v=0 r=0 af=0 ae=1 hw=0",
               a_count, a_out_valid, a_in_ready, a_af, a_ae, a_hw);
    else passed++;
    a_in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    total++; if (a_in_ready !== 1'b0) $display("FAIL reset_release_ready: got %b want 0", a_in_ready); else passed++;
    step();
    total++; if (a_in_ready !== 1'b1) $display("FAIL reset_ready_after_edge: got %b want 1", a_in_ready); else passed++;
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(8'h51 + i);
      step();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (a_out_valid !== 1'b1 || a_out_data !== 8'(8'h51 + i))
        $display("FAIL post_reset_read[%0d]: got v=%b d=%h want v=1 d=%h", i, a_out_valid, a_out_data, 8'(8'h51 + i));
      else passed++;
      step();
    end
    a_out_ready = 1'b0;
    total++; if (a_hw !== 3'd2 || a_count !== 3'd0) $display("FAIL post_reset_hw: got hw=%0d c=%0d want hw=2 c=0", a_hw, a_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_stream();
    test_registered_stream();
    test_full_simul();
    test_thresholds();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
